sd_data_ctrl: RTL and testbench

Parametrised data-line controller for the SD host: sequences single- and multi-block transfers between the FIFO side and the physical layer. Adds a programmable block count, per-block timeout, CRC-failure retry and abort. Sits between the DMA/register front end and the serial physical layer, replacing the fixed-width DATA controller.

---
 rtl/sd_data_pkg.sv | 33 +++
 rtl/sd_data_timeout.sv | 33 +++
 rtl/sd_data_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sd_data_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_data_pkg.sv
// Shared definitions for the SD data-line controller: FSM state encoding,
// debug view, default widths and SD data-path constants.
package sd_data_pkg;

   // Default parameter values for the controller
   localparam int DEF_BLK_CNT_W = 8;
   localparam int DEF_TOUT_W    = 16;
   localparam int DEF_MAX_RETRY = 2;

   // SD data-path constants shared with the physical layer
   localparam int SD_BLOCK_LEN  = 512;   // bytes per data block
   localparam int SD_CRC_W      = 16;    // CRC16 per data line

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CHECK_FIFO = 3'd1,
      ST_WAIT_PHY   = 3'd2,
      ST_TRANSFER   = 3'd3,
      ST_DONE       = 3'd4
   } sd_data_state_e;

   // Debug view of the controller: current state and latched direction
   typedef struct packed {
      sd_data_state_e state;
      logic           write_dir;
   } sd_data_dbg_t;

   // States in which the per-block timeout counter runs
   function automatic logic is_timed_state(input sd_data_state_e s);
      return (s == ST_CHECK_FIFO) || (s == ST_WAIT_PHY) || (s == ST_TRANSFER);
   endfunction

endpackage

// File: rtl/sd_data_timeout.sv
// Per-block timeout counter: synchronous clear, count enable, saturating
// count and a compare against a programmable limit.
module sd_data_timeout
   import sd_data_pkg::*;
#(
   parameter int TOUT_W = DEF_TOUT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              count_en,
   input  logic              enable,
   input  logic [TOUT_W-1:0] limit,
   output logic              hit
);

   logic [TOUT_W-1:0] count;

   // Count cycles since the last clear; hold at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != '1)) begin
         count <= count + TOUT_W'(1);
      end
   end

   // Limit reached; only meaningful while the timeout is enabled
   assign hit = enable && (count == limit);

endmodule

// File: rtl/sd_data_ctrl.sv
// SD host data-line controller. Sequences single- and multi-block transfers
// between the FIFO side and the serial physical layer, with a programmable
// block count, per-block timeout, CRC-failure retry and abort.
//
// Handshake with the physical layer: the controller holds Send high for the
// whole TRANSFER state; the physical layer answers with a one-cycle Complete
// pulse carrying Crc_ok. A block is started only after FIFO_ok and then
// Serial_ready have each been sampled high. All outputs are registered.
module sd_data_ctrl
   import sd_data_pkg::*;
#(
   parameter int BLK_CNT_W = DEF_BLK_CNT_W,
   parameter int TOUT_W    = DEF_TOUT_W,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 NewData,
   input  logic                 WriteRead,
   input  logic [BLK_CNT_W-1:0] Blocks,
   input  logic                 MultipleData,
   input  logic                 Timeout_enable,
   input  logic [TOUT_W-1:0]    Timeout_reg,
   input  logic                 FIFO_ok,
   input  logic                 Serial_ready,
   input  logic                 Complete,
   input  logic                 Crc_ok,
   input  logic                 Abort,
   output logic                 Send,
   output logic                 Idle,
   output logic                 Data_transfer_complete,
   output logic                 Timeout,
   output logic                 Crc_error,
   output logic                 Aborted,
   output logic [BLK_CNT_W-1:0] Blocks_done,
   output logic                 Busy,
   output sd_data_dbg_t         dbg
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   sd_data_state_e       state;
   sd_data_state_e       next_state;

   logic [BLK_CNT_W-1:0] target;
   logic [BLK_CNT_W-1:0] target_in;
   logic [BLK_CNT_W-1:0] blocks_next;
   logic [RETRY_W-1:0]   retry_cnt;
   logic                 write_q;

   // Per-cycle control decoded by the FSM
   logic                 start;
   logic                 blk_good;
   logic                 retry_inc;
   logic                 set_tout;
   logic                 set_crc;
   logic                 set_abort;

   logic                 tout_clear;
   logic                 tout_count_en;
   logic                 tout_hit;

   // Single-block requests always move exactly one block
   assign target_in   = MultipleData ? Blocks : BLK_CNT_W'(1);
   assign blocks_next = Blocks_done + BLK_CNT_W'(1);

   // Restart the timeout on every entry into a timed state, including the
   // TRANSFER -> WAIT_PHY resend path
   assign tout_clear    = (next_state != state) && is_timed_state(next_state);
   assign tout_count_en = is_timed_state(state);

   sd_data_timeout #(
      .TOUT_W (TOUT_W)
   ) u_timeout (
      .clk      (Clock),
      .rst_n    (Reset),
      .clear    (tout_clear),
      .count_en (tout_count_en),
      .enable   (Timeout_enable),
      .limit    (Timeout_reg),
      .hit      (tout_hit)
   );

   // State register
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. Priority: Abort > Complete > timeout.
   // Normal progress (FIFO_ok, Serial_ready) wins over a timeout hit in the
   // same cycle, matching Complete winning over timeout in TRANSFER.
   // DONE always returns to IDLE so the completion pulse stays one cycle wide.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      blk_good   = 1'b0;
      retry_inc  = 1'b0;
      set_tout   = 1'b0;
      set_crc    = 1'b0;
      set_abort  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (NewData) begin
               start      = 1'b1;
               next_state = (target_in == '0) ? ST_DONE : ST_CHECK_FIFO;
            end
         end
         ST_CHECK_FIFO: begin
            if (Abort) begin
               set_abort  = 1'b1;
               next_state = ST_DONE;
            end else if (FIFO_ok) begin
               next_state = ST_WAIT_PHY;
            end else if (tout_hit) begin
               set_tout   = 1'b1;
               next_state = ST_DONE;
            end
         end
         ST_WAIT_PHY: begin
            if (Abort) begin
               set_abort  = 1'b1;
               next_state = ST_DONE;
            end else if (Serial_ready) begin
               next_state = ST_TRANSFER;
            end else if (tout_hit) begin
               set_tout   = 1'b1;
               next_state = ST_DONE;
            end
         end
         ST_TRANSFER: begin
            if (Abort) begin
               set_abort  = 1'b1;
               next_state = ST_DONE;
            end else if (Complete) begin
               if (Crc_ok) begin
                  blk_good   = 1'b1;
                  next_state = (blocks_next == target) ? ST_DONE : ST_CHECK_FIFO;
               end else if (retry_cnt < RETRY_MAX) begin
                  retry_inc  = 1'b1;
                  next_state = ST_WAIT_PHY;
               end else begin
                  set_crc    = 1'b1;
                  next_state = ST_DONE;
               end
            end else if (tout_hit) begin
               set_tout   = 1'b1;
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Operation context: direction, target, progress and retry count
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         write_q     <= 1'b0;
         target      <= '0;
         Blocks_done <= '0;
         retry_cnt   <= '0;
      end else begin
         if (start) begin
            write_q     <= WriteRead;
            target      <= target_in;
            Blocks_done <= '0;
            retry_cnt   <= '0;
         end
         if (blk_good) begin
            Blocks_done <= blocks_next;
            retry_cnt   <= '0;
         end
         if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
         end
      end
   end

   // Sticky error/abort flags, cleared only when a new operation is accepted
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         Timeout   <= 1'b0;
         Crc_error <= 1'b0;
         Aborted   <= 1'b0;
      end else begin
         if (start) begin
            Timeout   <= 1'b0;
            Crc_error <= 1'b0;
            Aborted   <= 1'b0;
         end
         if (set_tout) begin
            Timeout <= 1'b1;
         end
         if (set_crc) begin
            Crc_error <= 1'b1;
         end
         if (set_abort) begin
            Aborted <= 1'b1;
         end
      end
   end

   // Moore outputs registered from the state being entered
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         Send                   <= 1'b0;
         Idle                   <= 1'b1;
         Data_transfer_complete <= 1'b0;
         Busy                   <= 1'b0;
      end else begin
         Send                   <= (next_state == ST_TRANSFER);
         Idle                   <= (next_state == ST_IDLE);
         Data_transfer_complete <= (next_state == ST_DONE);
         Busy                   <= (next_state != ST_IDLE);
      end
   end

   assign dbg = '{state: state, write_dir: write_q};

endmodule

// File: tb/tb_sd_data_ctrl.sv
// Bench for sd_data_ctrl: directed operations, a behavioural physical layer,
// and a scoreboard checking every completion pulse against an expected result.
module tb_sd_data_ctrl;
   import sd_data_pkg::*;

   localparam int BW = 8;
   localparam int TW = 16;
   localparam int RW = 19;   // {windows[7:0], Timeout, Crc_error, Aborted, Blocks_done[7:0]}

   // ---------------- clock / reset ----------------
   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- DUT signals ----------------
   logic          NewData = 1'b0;
   logic          WriteRead = 1'b0;
   logic [BW-1:0] Blocks = '0;
   logic          MultipleData = 1'b0;
   logic          Timeout_enable = 1'b0;
   logic [TW-1:0] Timeout_reg = '0;
   logic          FIFO_ok = 1'b0;
   logic          Serial_ready = 1'b0;
   logic          Abort = 1'b0;
   logic          Complete;
   logic          Crc_ok;
   logic          phy_complete = 1'b0;
   logic          phy_crc = 1'b0;
   logic          man_complete = 1'b0;
   logic          man_crc = 1'b0;
   logic          phy_en = 1'b0;

   logic          Send;
   logic          Idle;
   logic          Data_transfer_complete;
   logic          Timeout;
   logic          Crc_error;
   logic          Aborted;
   logic [BW-1:0] Blocks_done;
   logic          Busy;
   sd_data_dbg_t  dbg;

   assign Complete = phy_complete | man_complete;
   assign Crc_ok   = phy_complete ? phy_crc : man_crc;

   sd_data_ctrl #(
      .BLK_CNT_W (BW),
      .TOUT_W    (TW),
      .MAX_RETRY (2)
   ) dut (
      .Clock                  (Clock),
      .Reset                  (Reset),
      .NewData                (NewData),
      .WriteRead              (WriteRead),
      .Blocks                 (Blocks),
      .MultipleData           (MultipleData),
      .Timeout_enable         (Timeout_enable),
      .Timeout_reg            (Timeout_reg),
      .FIFO_ok                (FIFO_ok),
      .Serial_ready           (Serial_ready),
      .Complete               (Complete),
      .Crc_ok                 (Crc_ok),
      .Abort                  (Abort),
      .Send                   (Send),
      .Idle                   (Idle),
      .Data_transfer_complete (Data_transfer_complete),
      .Timeout                (Timeout),
      .Crc_error              (Crc_error),
      .Aborted                (Aborted),
      .Blocks_done            (Blocks_done),
      .Busy                   (Busy),
      .dbg                    (dbg)
   );

   // ---------------- scoreboard state ----------------
   logic [RW-1:0] exp_q[$];
   logic          crc_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   function automatic logic [RW-1:0] pack_res(input int win, input logic t, input logic c,
                                              input logic a, input logic [BW-1:0] d);
      return {8'(win), t, c, a, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural physical layer ----------------
   // After Send has been high for two cycles, answer with one Complete pulse
   // whose CRC status comes from crc_q.
   initial begin : phy
      int age;
      age = 0;
      forever begin
         @(posedge Clock);
         #1;
         if (phy_complete) begin
            phy_complete = 1'b0;
            phy_crc      = 1'b0;
            age          = 0;
         end else if (phy_en && Send) begin
            age++;
            if (age >= 2 && crc_q.size() > 0) begin
               phy_crc      = crc_q.pop_front();
               phy_complete = 1'b1;
               age          = 0;
            end
         end else begin
            age = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   // Counts Send windows and, on each completion pulse, compares the
   // operation result with the oldest expected entry.
   initial begin : monitor
      int            win;
      logic          send_prev;
      logic [RW-1:0] exp_v;
      logic [RW-1:0] act_v;
      win       = 0;
      send_prev = 1'b0;
      forever begin
         @(negedge Clock);
         if (!Reset) begin
            win = 0;
         end else begin
            if (Send && !send_prev) win++;
            if (Data_transfer_complete) begin
               n_checks++;
               act_v = pack_res(win, Timeout, Crc_error, Aborted, Blocks_done);
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_done: pulse with nothing expected, got win=%0d t=%0b c=%0b a=%0b done=%0d",
                           act_v[18:11], act_v[10], act_v[9], act_v[8], act_v[7:0]);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (act_v !== exp_v) begin
                     n_errors++;
                     $display("FAIL op_result: got win=%0d t=%0b c=%0b a=%0b done=%0d, expected win=%0d t=%0b c=%0b a=%0b done=%0d",
                              act_v[18:11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                              exp_v[18:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
                  end
               end
               win = 0;
            end
         end
         send_prev = Send;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 just after the sampling edge.
   task automatic start_op(input logic wr, input logic multi, input logic [BW-1:0] blks);
      WriteRead    = wr;
      MultipleData = multi;
      Blocks       = blks;
      NewData      = 1'b1;
      @(posedge Clock);
      #1;
      NewData      = 1'b0;
   endtask

   // Negedges until the completion pulse is seen (1 = right after the sampling edge)
   task automatic wait_dtc(input string name, input int max, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < max) begin
         @(negedge Clock);
         cycles++;
         if (Data_transfer_complete) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: no completion pulse within %0d cycles", name, max);
      end
   endtask

   // Negedges until Send is high
   task automatic wait_send(input string name, input int max, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < max) begin
         @(negedge Clock);
         cycles++;
         if (Send) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: Send not seen within %0d cycles", name, max);
      end
   endtask

   // After the pulse: Idle must follow one cycle later, then realign
   task automatic finish_op(input string name);
      @(negedge Clock);
      check({name, "_idle_after"}, {31'd0, Idle}, 32'd1);
      check({name, "_pulse_width"}, {31'd0, Data_transfer_complete}, 32'd0);
      @(posedge Clock);
      #1;
   endtask

   // Run one operation driven by the behavioural physical layer
   task automatic run_phy_op(input string name, input logic wr, input logic multi,
                             input logic [BW-1:0] blks);
      int cyc;
      phy_en = 1'b1;
      start_op(wr, multi, blks);
      wait_dtc(name, 200, cyc);
      finish_op(name);
      phy_en = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int cyc;
      int dtc_seen;

      // Reset
      Reset = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(negedge Clock);
      check("rst_idle", {31'd0, Idle}, 32'd1);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_send", {31'd0, Send}, 32'd0);
      check("rst_dtc", {31'd0, Data_transfer_complete}, 32'd0);
      check("rst_flags", {29'd0, Timeout, Crc_error, Aborted}, 32'd0);
      check("rst_blocks_done", {24'd0, Blocks_done}, 32'd0);
      check("rst_state", {29'd0, dbg.state}, {29'd0, ST_IDLE});
      @(posedge Clock);
      #1;

      // Single-block write: Blocks=5 ignored because MultipleData=0
      FIFO_ok      = 1'b1;
      Serial_ready = 1'b1;
      phy_en       = 1'b1;
      crc_q.push_back(1'b1);
      exp_q.push_back(pack_res(1, 1'b0, 1'b0, 1'b0, 8'd1));
      start_op(1'b1, 1'b0, 8'd5);
      wait_send("single_send", 10, cyc);
      check("newdata_to_send", cyc, 3);
      check("write_dir_latched", {31'd0, dbg.write_dir}, 32'd1);
      check("busy_in_op", {31'd0, Busy}, 32'd1);
      wait_dtc("single_done", 50, cyc);
      finish_op("single");
      phy_en = 1'b0;

      // Multi-block read, three good blocks
      crc_q = '{1'b1, 1'b1, 1'b1};
      exp_q.push_back(pack_res(3, 1'b0, 1'b0, 1'b0, 8'd3));
      run_phy_op("multi3", 1'b0, 1'b1, 8'd3);
      check("read_dir_latched", {31'd0, dbg.write_dir}, 32'd0);

      // Two CRC failures then success: block resent twice, no error
      crc_q = '{1'b0, 1'b0, 1'b1};
      exp_q.push_back(pack_res(3, 1'b0, 1'b0, 1'b0, 8'd1));
      run_phy_op("retry_ok", 1'b1, 1'b0, 8'd1);

      // Three CRC failures in a row: retries exhausted
      crc_q = '{1'b0, 1'b0, 1'b0};
      exp_q.push_back(pack_res(3, 1'b0, 1'b1, 1'b0, 8'd0));
      run_phy_op("retry_fail", 1'b1, 1'b0, 8'd1);

      // Multi-block request with zero blocks goes straight to DONE
      exp_q.push_back(pack_res(0, 1'b0, 1'b0, 1'b0, 8'd0));
      start_op(1'b0, 1'b1, 8'd0);
      wait_dtc("zero_blocks", 10, cyc);
      check("zero_blocks_latency", cyc, 1);
      finish_op("zero_blocks");

      // Timeout with limit 70 while the FIFO never becomes ready:
      // pulse 71 cycles after the edge that enters CHECK_FIFO
      FIFO_ok        = 1'b0;
      Timeout_enable = 1'b1;
      Timeout_reg    = 16'd70;
      exp_q.push_back(pack_res(0, 1'b1, 1'b0, 1'b0, 8'd0));
      start_op(1'b1, 1'b0, 8'd1);
      wait_dtc("timeout70", 200, cyc);
      check("timeout70_latency", cyc - 1, 71);
      finish_op("timeout70");

      // Timeout limit 0 fires one cycle after entry
      Timeout_reg = 16'd0;
      exp_q.push_back(pack_res(0, 1'b1, 1'b0, 1'b0, 8'd0));
      start_op(1'b1, 1'b0, 8'd1);
      wait_dtc("timeout0", 20, cyc);
      check("timeout0_latency", cyc - 1, 1);
      finish_op("timeout0");

      // Timeout disabled: no completion for 1000 cycles, then abort
      Timeout_enable = 1'b0;
      Timeout_reg    = 16'd5;
      start_op(1'b1, 1'b0, 8'd1);
      dtc_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clock);
         if (Data_transfer_complete) dtc_seen++;
      end
      check("no_timeout_pulses", dtc_seen, 0);
      check("no_timeout_flag", {31'd0, Timeout}, 32'd0);
      check("no_timeout_busy", {31'd0, Busy}, 32'd1);
      exp_q.push_back(pack_res(0, 1'b0, 1'b0, 1'b1, 8'd0));
      @(posedge Clock);
      #1;
      Abort = 1'b1;
      @(posedge Clock);
      #1;
      Abort = 1'b0;
      wait_dtc("abort_check_fifo", 5, cyc);
      check("abort_check_fifo_latency", cyc, 1);
      finish_op("abort_check_fifo");

      // Abort together with a good Complete in TRANSFER: abort wins
      FIFO_ok      = 1'b1;
      Serial_ready = 1'b1;
      exp_q.push_back(pack_res(1, 1'b0, 1'b0, 1'b1, 8'd0));
      start_op(1'b0, 1'b1, 8'd2);
      wait_send("abort_send", 10, cyc);
      @(posedge Clock);
      #1;
      man_complete = 1'b1;
      man_crc      = 1'b1;
      Abort        = 1'b1;
      @(posedge Clock);
      #1;
      man_complete = 1'b0;
      man_crc      = 1'b0;
      Abort        = 1'b0;
      @(negedge Clock);
      check("abort_done_next", {31'd0, Data_transfer_complete}, 32'd1);
      check("abort_flag", {31'd0, Aborted}, 32'd1);
      check("abort_blocks_done", {24'd0, Blocks_done}, 32'd0);
      finish_op("abort_transfer");

      // Abort in IDLE is ignored
      Abort = 1'b1;
      @(posedge Clock);
      #1;
      Abort = 1'b0;
      @(negedge Clock);
      check("idle_abort_busy", {31'd0, Busy}, 32'd0);
      check("idle_abort_idle", {31'd0, Idle}, 32'd1);
      @(posedge Clock);
      #1;

      // Reset mid-transfer after one good block: back to IDLE, no pulse
      crc_q  = '{1'b1};
      phy_en = 1'b1;
      start_op(1'b1, 1'b1, 8'd3);
      cyc = 0;
      while (!(Blocks_done == 8'd1 && Send) && cyc < 50) begin
         @(negedge Clock);
         cyc++;
      end
      check("mid_reset_setup_blocks", {24'd0, Blocks_done}, 32'd1);
      check("mid_reset_setup_send", {31'd0, Send}, 32'd1);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(negedge Clock);
      check("mid_reset_idle", {31'd0, Idle}, 32'd1);
      check("mid_reset_busy", {31'd0, Busy}, 32'd0);
      check("mid_reset_send", {31'd0, Send}, 32'd0);
      check("mid_reset_blocks_done", {24'd0, Blocks_done}, 32'd0);
      check("mid_reset_flags", {29'd0, Timeout, Crc_error, Aborted}, 32'd0);
      check("mid_reset_dtc", {31'd0, Data_transfer_complete}, 32'd0);
      phy_en = 1'b0;
      repeat (5) @(negedge Clock);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
